// File: rtl/sample_capture_pkg.sv
// Shared types for the sample capture buffer.
// No logic here: state encoding only.
// No handshake: type definitions only.
package sample_capture_pkg;

  // Capture controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/sample_capture_ram.sv
// Simple dual-port sample RAM: one write port and one registered read port.
// Read latency: one cycle (rdata valid after the edge that samples raddr); read-before-write on collision.
// Backpressure: none; a write happens on every edge with we high.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset (rdata only; array not cleared)
//   we/waddr/wdata write enable, address, data
//   raddr/rdata    read address, registered read data
module capture_ram #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // The array read is taken before this edge's write lands, so a
  // same-address collision returns the previous contents.
  always_comb begin
    rdata_d = mem[raddr];
  end

  // Storage is deliberately left out of reset so captured data survives it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sample_capture.sv
// Trigger-started sample capture into a 2**ADDRESS_WIDTH RAM with registered random-access readback.
// Write: accepted sample readable one edge later; read: one-cycle registered latency.
// Backpressure: din_ready low in IDLE/DONE and in ARMED without trigger; unaccepted samples are dropped.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   arm, trigger          start-capture request and start-of-capture event
//   din/din_valid/din_ready  sample stream in (valid/ready)
//   busy, done, count     status: ARMED|CAPTURE, buffer full, samples written
//   rd_addr, dout         readback address and registered data
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     trigger,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   count,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    dout
);

  // count value meaning "every location written": only the top bit set.
  localparam logic [ADDRESS_WIDTH:0] FULL_COUNT = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] ONE        = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  state_e                 state_d;
  state_e                 state_q;
  logic [ADDRESS_WIDTH:0] count_d;
  logic [ADDRESS_WIDTH:0] count_q;
  logic                   accept;
  logic                   we;

  // State and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and count update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          count_d = '0;
        end
      end
      ARMED: begin
        if (trigger) begin
          state_d = CAPTURE;
          // The trigger-cycle sample, if present, lands at address 0.
          if (accept) begin
            count_d = count_q + ONE;
            if (count_d == FULL_COUNT) begin
              state_d = DONE;
            end
          end
        end
      end
      CAPTURE: begin
        if (accept) begin
          count_d = count_q + ONE;
          if (count_d == FULL_COUNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (arm) begin
          state_d = ARMED;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Output decode. din_ready in ARMED follows trigger so the sample that
  // arrives with the trigger is not lost.
  always_comb begin
    din_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ARMED: begin
        din_ready = trigger;
        busy      = 1'b1;
      end
      CAPTURE: begin
        din_ready = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        din_ready = 1'b0;
      end
    endcase
  end

  assign accept = din_valid && din_ready;
  // The full-count guard keeps the write address from ever wrapping.
  assign we     = accept && (count_q != FULL_COUNT);
  assign count  = count_q;

  capture_ram #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (count_q[ADDRESS_WIDTH-1:0]),
    .wdata (din),
    .raddr (rd_addr),
    .rdata (dout)
  );

endmodule
